// File: rtl/mux_tb_pkg.sv
// Shared definitions for the 2:1 mux stimulus generator.
//   state_t    : controller states
//   LFSR_TAPS  : Fibonacci tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   DEF_*      : default parameter values for mux_stim_gen
//   lfsr_next  : one left-shift step of the LFSR
//   seed_fix   : maps the lock-up seed 0 to 1
package mux_tb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_TAPS       = 8'hB8;
    localparam logic [7:0] DEF_SEED        = 8'hA5;
    localparam int         DEF_NUM_VEC     = 10;
    localparam int         DEF_HOLD_CYCLES = 5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero LFSR never leaves zero, so that seed is replaced.
    function automatic logic [7:0] seed_fix(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, shifting left with feedback into bit 0.
//   clk   : clock
//   rst   : synchronous active-high reset, loads seed
//   load  : load seed (optionally advanced one step when step is also high)
//   step  : advance one step
//   seed  : seed value (must be non-zero)
//   state : current LFSR contents
module lfsr8
    import mux_tb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] state
);

    // load+step together consumes the seed in the same edge, so the next
    // vector request sees the value following the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed;
        end else if (load) begin
            state <= step ? lfsr_next(seed) : seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/mux_stim_gen.sv
// Stimulus generator and checker for three 2:1 mux implementations.
// Drives pseudo-random {sel,in0,in1} vectors, waits HOLD_CYCLES settle
// cycles per vector and compares out1/out2/out3 with sel ? in1 : in0.
//   clk, rst            : clock, synchronous active-high reset
//   start               : run request, honoured only in IDLE or DONE
//   out1, out2, out3    : mux outputs under test
//   sel, in0, in1       : registered stimulus
//   vec_valid           : first cycle of a new vector
//   sample              : last settle cycle of a vector (check point)
//   err                 : one-cycle pulse after a mismatching sample
//   err_cnt             : mismatching vectors this run, saturating at 255
//   vec_idx             : index of the vector currently driven
//   busy, done          : run in progress / run finished
module mux_stim_gen
    import mux_tb_pkg::*;
#(
    parameter logic [7:0] SEED        = DEF_SEED,
    parameter int         NUM_VEC     = DEF_NUM_VEC,
    parameter int         HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       out1,
    input  logic       out2,
    input  logic       out3,
    output logic       sel,
    output logic       in0,
    output logic       in1,
    output logic       vec_valid,
    output logic       sample,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [7:0] vec_idx,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] SEED_EFF = seed_fix(SEED);
    localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);
    localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] lfsr_q;
    logic       go;
    logic       hold_end;
    logic       last_vec;
    logic       next_vec;
    logic       expected;
    logic       match;
    logic       mismatch;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (go),
        .step  (go | next_vec),
        .seed  (SEED_EFF),
        .state (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        hold_end  = (state == HOLD) && (cnt == LAST_CNT);
        last_vec  = (vec_idx == LAST_IDX);
        next_vec  = 1'b0;
        vec_valid = (state == APPLY);
        sample    = hold_end;
        busy      = (state == APPLY) || (state == HOLD);
        done      = (state == DONE);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    go        = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY: state_nxt = HOLD;
            HOLD: begin
                if (hold_end) begin
                    next_vec  = !last_vec;
                    state_nxt = last_vec ? DONE : APPLY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Any X/Z on a mux output makes match non-1 and counts as a mismatch.
    always_comb begin
        expected = sel ? in1 : in0;
        match    = ({out1, out2, out3} == {3{expected}});
        mismatch = (match !== 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel     <= 1'b0;
            in0     <= 1'b0;
            in1     <= 1'b0;
            cnt     <= 8'd0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
            vec_idx <= 8'd0;
        end else begin
            err <= 1'b0;
            // The first vector comes straight from the seed; later vectors
            // use the LFSR, which the same edge advances.
            if (go) begin
                {sel, in0, in1} <= SEED_EFF[2:0];
                err_cnt         <= 8'd0;
                vec_idx         <= 8'd0;
            end else if (next_vec) begin
                {sel, in0, in1} <= lfsr_q[2:0];
                vec_idx         <= vec_idx + 8'd1;
            end
            if (state == APPLY) begin
                cnt <= 8'd0;
            end else if (state == HOLD) begin
                cnt <= cnt + 8'd1;
            end
            if (sample && mismatch) begin
                err     <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_mux_stim_gen.sv
module tb_mux_stim_gen;

    localparam int N     = 10;
    localparam int H     = 5;
    localparam int P     = H + 1;
    localparam int TOTAL = N * P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       out1 = 1'b0, out2 = 1'b0, out3 = 1'b0;
    logic       sel, in0, in1, vec_valid, sample, err, busy, done;
    logic [7:0] err_cnt, vec_idx;

    logic       start_s = 1'b0;
    logic       s_sel, s_in0, s_in1, s_vec_valid, s_sample, s_err, s_busy, s_done;
    logic [7:0] s_err_cnt, s_vec_idx;
    logic       s_out;

    always #5 clk = ~clk;

    mux_stim_gen dut (
        .clk(clk), .rst(rst), .start(start),
        .out1(out1), .out2(out2), .out3(out3),
        .sel(sel), .in0(in0), .in1(in1),
        .vec_valid(vec_valid), .sample(sample), .err(err),
        .err_cnt(err_cnt), .vec_idx(vec_idx), .busy(busy), .done(done)
    );

    assign s_out = s_sel ? s_in1 : s_in0;

    mux_stim_gen #(.SEED(8'hA5), .NUM_VEC(1), .HOLD_CYCLES(1)) dut_small (
        .clk(clk), .rst(rst), .start(start_s),
        .out1(s_out), .out2(s_out), .out3(s_out),
        .sel(s_sel), .in0(s_in0), .in1(s_in1),
        .vec_valid(s_vec_valid), .sample(s_sample), .err(s_err),
        .err_cnt(s_err_cnt), .vec_idx(s_vec_idx), .busy(s_busy), .done(s_done)
    );

    typedef struct {
        int         idx;
        logic [2:0] vec;
    } row_t;

    row_t       tbl [5];
    logic [2:0] ref_vec [N];
    int         errors = 0;
    int         checks = 0;
    int         err_pulses;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mode 0: ideal mux, 1: out2 stuck low when sel=1,in1=1, 2: random faults
    task automatic run(input int mode, input int restart_k, input int abort_k);
        int         cnt_m;
        logic       err_m;
        int         k, ph, t_done;
        logic       is_done, mis, e;
        logic [2:0] ev, flips;
        cnt_m      = 0;
        err_m      = 1'b0;
        t_done     = -1;
        err_pulses = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int t = 1; t <= TOTAL + 3; t++) begin
            is_done = (t > TOTAL);
            k  = is_done ? N - 1 : (t - 1) / P;
            ph = is_done ? -1 : (t - 1) % P;
            ev = ref_vec[k];
            chk("stim", {sel, in0, in1}, ev);
            chk("ctrl", {vec_valid, sample, err, busy, done},
                {ph == 0, ph == H, err_m, !is_done, is_done});
            chk("err_cnt", err_cnt, cnt_m);
            chk("vec_idx", vec_idx, k);
            if (mode == 0 && ph == 0)
                for (int r = 0; r < 5; r++)
                    if (tbl[r].idx == k) chk("table_vec", {sel, in0, in1}, tbl[r].vec);
            if (err === 1'b1) err_pulses++;
            if (done === 1'b1 && t_done < 0) t_done = t;

            mis = 1'b0;
            if (ph == H) begin
                e     = ev[2] ? ev[0] : ev[1];
                flips = 3'b000;
                if (mode == 1 && ev[2] && ev[0]) flips = 3'b010;
                if (mode == 2 && $urandom_range(0, 2) == 0) flips = 3'($urandom_range(1, 7));
                {out1, out2, out3} = {3{e}} ^ flips;
                mis = (flips != 3'b000);
            end else begin
                {out1, out2, out3} = (mode == 2) ? 3'($urandom_range(0, 7)) : 3'b000;
            end
            err_m = mis;
            if (mis && cnt_m < 255) cnt_m++;

            start = (k == restart_k && ph == 2) ? 1'b1 : 1'b0;
            if (k == abort_k && ph == 2) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_zero", {sel, in0, in1, vec_valid, sample, err, busy, done, err_cnt, vec_idx}, 0);
                @(negedge clk);
                chk("abort_no_residue", {sel, in0, in1, vec_valid, sample, err, busy, done, err_cnt, vec_idx}, 0);
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_latency", t_done, TOTAL + 1);
    endtask

    initial begin
        int s;
        tbl[0] = '{0, 3'b101};
        tbl[1] = '{1, 3'b010};
        tbl[2] = '{2, 3'b101};
        tbl[3] = '{3, 3'b010};
        tbl[4] = '{4, 3'b100};
        s = 8'hA5;
        for (int i = 0; i < N; i++) begin
            ref_vec[i] = 3'(s % 8);
            s = ((s * 2) % 256) + ($countones(s & 8'hB8) % 2);
        end

        // reset must win over a concurrent start
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_stim", {sel, in0, in1}, 3'b000);
        chk("rst_ctrl", {vec_valid, sample, err, busy, done}, 5'b0);
        chk("rst_cnt", {err_cnt, vec_idx}, 16'h0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {busy, done, vec_valid}, 3'b000);

        // single-vector, single-settle-cycle instance
        start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        chk("small_apply", {s_vec_valid, s_sample, s_busy, s_done, s_sel, s_in0, s_in1}, 7'b1010_101);
        @(negedge clk);
        chk("small_hold", {s_vec_valid, s_sample, s_busy, s_done}, 4'b0110);
        @(negedge clk);
        chk("small_done", {s_vec_valid, s_sample, s_busy, s_done, s_err, s_err_cnt}, {4'b0001, 1'b0, 8'd0});

        run(0, -1, -1);
        chk("ideal_err_pulses", err_pulses, 0);
        run(1, -1, -1);
        chk("stuck_err_cnt", err_cnt, 4);
        chk("stuck_err_pulses", err_pulses, 4);
        repeat (20) run(2, -1, -1);
        run(0, 3, -1);
        run(0, -1, 2);
        run(0, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_stim_gen.md
MUX_STIM_GEN -- requirements
Module: mux_stim_gen

Interface
REQ-001 Parameter SEED, default 8'hA5, LFSR seed loaded on every start; value 8'h00 SHALL be replaced by 8'h01.
REQ-002 Parameter NUM_VEC, default 10, vectors per run; legal range 1..255.
REQ-003 Parameter HOLD_CYCLES, default 5, settle cycles per vector before sampling; legal range 1..255.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  run request, sampled only in IDLE or DONE.
REQ-007 out1, out2, out3  input  1 each  outputs of the three 2:1 mux implementations under test.
REQ-008 sel, in0, in1  output  1 each  registered stimulus to the mux inputs.
REQ-009 vec_valid  output  1  high for the single cycle in which a new vector first appears.
REQ-010 sample  output  1  high in the last settle cycle of each vector; this is the check point.
REQ-011 err  output  1  registered one-cycle pulse, the cycle after a sample that mismatched.
REQ-012 err_cnt  output  8  count of mismatching vectors in the current run; saturates at 255.
REQ-013 vec_idx  output  8  index of the vector currently driven, 0..NUM_VEC-1.
REQ-014 busy  output  1  high in APPLY and HOLD.
REQ-015 done  output  1  high in DONE.

Function
REQ-016 FSM states SHALL be IDLE, APPLY, HOLD and DONE.
- IDLE/DONE with start=1 -> APPLY.
- APPLY -> HOLD after exactly one cycle.
- HOLD -> APPLY when the settle count reaches HOLD_CYCLES-1 and vec_idx < NUM_VEC-1.
- HOLD -> DONE when the settle count reaches HOLD_CYCLES-1 and vec_idx = NUM_VEC-1.
REQ-017 On the start edge, the LFSR SHALL load SEED; err_cnt and vec_idx SHALL clear to 0.
REQ-018 On every edge entering APPLY, {sel,in0,in1} SHALL load the current LFSR[2:0], and the LFSR SHALL then advance one step.
REQ-019 The LFSR SHALL be 8-bit Fibonacci with polynomial x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
REQ-020 vec_valid SHALL equal (state==APPLY).
REQ-021 The settle counter SHALL clear on entering HOLD; sample SHALL equal (state==HOLD and count==HOLD_CYCLES-1).
REQ-022 Each vector SHALL last exactly 1+HOLD_CYCLES cycles; a run SHALL last NUM_VEC*(1+HOLD_CYCLES) cycles from start edge to the done rising edge.
REQ-023 At a sample cycle, expected = sel ? in1 : in0.
- A mismatch is any of out1/out2/out3 != expected, or any X/Z value.
- On a mismatch, err SHALL pulse and err_cnt SHALL increment at the sample edge, both visible the next cycle.
REQ-024 vec_idx SHALL increment on each HOLD->APPLY transition and SHALL never wrap within a run.
REQ-025 start while busy SHALL be ignored.
REQ-026 DONE SHALL hold all outputs stable until start or rst; err_cnt SHALL stay readable in DONE.
REQ-027 Stimulus outputs SHALL keep their last vector in DONE.

Reset
REQ-028 On rst=1 at a clock edge:
- state=IDLE;
- sel, in0, in1, vec_valid, sample, err, busy, done = 0;
- err_cnt = 0, vec_idx = 0;
- LFSR = SEED (or 8'h01 if SEED is zero).
REQ-029 rst SHALL override start and abort a run mid-vector with no residual pulse on the following cycle.

Structure
REQ-030 Package mux_tb_pkg SHALL hold the state enum, the LFSR tap mask 8'hB8, and the default SEED/NUM_VEC/HOLD_CYCLES constants.
REQ-031 The LFSR SHALL be a sub-module lfsr8 (load, step, seed in, 8-bit state out); the FSM, counters and checker SHALL stay in mux_stim_gen.

Verification
REQ-032 Reset, then start with defaults -> first vector {sel,in0,in1}=3'b101 with vec_valid high one cycle; sample 5 cycles later; done rises 60 cycles after the start edge.
REQ-033 Outputs driven by an ideal mux model -> err never pulses and err_cnt=0 at done.
REQ-034 out2 forced to 0 while sel=1,in1=1 occurs k times -> err pulses k times and err_cnt=k.
REQ-035 start pulsed during HOLD of vector 3 -> no restart, vec_idx continues 4..9, run length unchanged.
REQ-036 rst asserted mid-HOLD of vector 2, then start -> all outputs 0 after the reset edge; the new run replays the identical vector sequence from 3'b101.
REQ-037 NUM_VEC=1, HOLD_CYCLES=1 -> APPLY, HOLD, DONE in 2 cycles; sample coincides with the only HOLD cycle.
